uart_tx: RTL
============

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLK_FRQ, default 50000000, source clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, line bit rate in bit/s.
REQ-003 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  level request to send data; sampled every clk.
REQ-006 SHALL have port data  input  8  byte to transmit, captured on accept.
REQ-007 SHALL have port cts  input  1  clear to send, active-high; gates frame acceptance only.
REQ-008 SHALL have port tx  output  1  serial line, idle high.
REQ-009 SHALL have port busy  output  1  high while a frame is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse when a frame completes.

Function
REQ-011 SHALL define BIT_CYCLES = CLK_FRQ / BAUD_RATE (integer truncation): 434 at defaults; BIT_CYCLES < 2 is illegal.
REQ-012 SHALL implement states IDLE, START, DATA, PARITY, STOP; all other encodings go to IDLE.
REQ-013 SHALL accept a frame at a clk edge only when state==IDLE, start==1, cts==1; data captured into a shift register at that edge.
REQ-014 SHALL ignore start while busy, and ignore start while cts==0 without queuing it.
REQ-015 SHALL drive tx=0 for exactly BIT_CYCLES cycles in START, starting the cycle after accept.
REQ-016 SHALL send 8 data bits LSB first, each held exactly BIT_CYCLES cycles; changes in data after accept SHALL NOT affect the frame.
REQ-017 SHALL send parity bit = XOR of the 8 captured bits (even parity) for BIT_CYCLES cycles in PARITY.
REQ-018 SHALL drive tx=1 for BIT_CYCLES cycles in STOP, then return to IDLE.
REQ-019 SHALL assert busy from the cycle after accept through the last STOP cycle inclusive.
REQ-020 SHALL pulse done for exactly one cycle, the first IDLE cycle after STOP; busy=0 in that cycle.
REQ-021 SHALL allow back-to-back frames: start=1, cts=1 in the done cycle is accepted; the next start bit follows after exactly one idle-high cycle.
REQ-022 SHALL drive tx=1 in IDLE; tx SHALL be registered (no combinational glitches).
REQ-023 SHALL NOT re-check cts mid-frame; deassertion of cts mid-frame SHALL NOT abort the frame.

Reset
REQ-024 SHALL, while reset==1 at a clk edge, force state=IDLE, tx=1, busy=0, done=0, and clear bit and baud counters.
REQ-025 SHALL abort any frame when reset asserts mid-frame; tx=1 the following cycle and no done pulse for the aborted frame.
REQ-026 SHALL ignore start in any cycle where reset==1.

Configuration
REQ-027 SHALL use macro UART_TX_PARITY_EN: when defined, the PARITY state is present and the frame is 11 bits (4774 cycles at defaults).
REQ-028 SHALL, when UART_TX_PARITY_EN is undefined, skip PARITY (DATA goes directly to STOP) and send a 10-bit frame (4340 cycles at defaults); ports are unchanged.

Verification
REQ-029 SHALL cover: reset, then data=0x55, start pulse, cts=1 -> tx bits 0,1,0,1,0,1,0,1,0,0,1, each held 434 cycles; busy high 4774 cycles; done pulses once at cycle 4775.
REQ-030 SHALL cover: data=0x80 then data=0x00 (parity macro defined) -> parity bit 1, then 0; frame lengths 4774 cycles each.
REQ-031 SHALL cover: cts=0, start held 1000 cycles -> tx stays 1, busy 0; raising cts -> frame starts the next cycle.
REQ-032 SHALL cover: start held high, data=0xA3 -> consecutive frames separated by exactly one idle-high cycle; data changed mid-frame to 0xFF does not alter the current frame.
REQ-033 SHALL cover: reset asserted during DATA bit 3 -> tx=1 next cycle, busy=0, no done; a subsequent frame with data=0x3C is correct.
REQ-034 SHALL cover: UART_TX_PARITY_EN undefined, data=0x55 -> 10-bit frame 0,1,0,1,0,1,0,1,0,1 of 4340 cycles, done at cycle 4341.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional even parity, one stop bit.
// Optional parity stage is enabled by defining UART_TX_PARITY_EN.
module uart_tx #(
  parameter int unsigned CLK_FRQ   = 50000000,
  parameter int unsigned BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  input  logic       cts,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  // BIT_CYCLES below 2 is not a supported configuration.
  localparam int unsigned BIT_CYCLES = CLK_FRQ / BAUD_RATE;
  localparam int unsigned CW         = $clog2(BIT_CYCLES);
  localparam logic [CW-1:0] LAST_CNT = CW'(BIT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t        state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
`ifdef UART_TX_PARITY_EN
  logic          par;
`endif
  logic          bit_end_c;

  assign bit_end_c = (baud_cnt == LAST_CNT);

  // Frame sequencer; tx/busy/done are all registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
`ifdef UART_TX_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          bit_cnt  <= '0;
          if (start && cts) begin
            state <= START;
            shreg <= data;
`ifdef UART_TX_PARITY_EN
            par   <= ^data;
`endif
            tx    <= 1'b0;
            busy  <= 1'b1;
          end else begin
            tx   <= 1'b1;
            busy <= 1'b0;
          end
        end
        START: begin
          if (bit_end_c) begin
            baud_cnt <= '0;
            state    <= DATA;
            tx       <= shreg[0];
            shreg    <= {1'b0, shreg[7:1]};
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        DATA: begin
          if (bit_end_c) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
              tx    <= par;
`else
              state <= STOP;
              tx    <= 1'b1;
`endif
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              tx      <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end_c) begin
            baud_cnt <= '0;
            state    <= STOP;
            tx       <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
`endif
        STOP: begin
          if (bit_end_c) begin
            baud_cnt <= '0;
            state    <= IDLE;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        default: begin
          state    <= IDLE;
          tx       <= 1'b1;
          busy     <= 1'b0;
          baud_cnt <= '0;
          bit_cnt  <= '0;
        end
      endcase
    end
  end

endmodule
